// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the anti-theft alarm: interval codes, default
// delays and the timer state encoding used by both the timer and the FSM.
package alarm_timer_pkg;

  // Delay select codes (interval / time_param_sel)
  localparam logic [1:0] INT_ARM    = 2'b00;
  localparam logic [1:0] INT_DRIVER = 2'b01;
  localparam logic [1:0] INT_PASS   = 2'b10;
  localparam logic [1:0] INT_ALARM  = 2'b11;

  // Default delays in seconds
  localparam int T_ARM_DEF_S    = 6;
  localparam int T_DRIVER_DEF_S = 8;
  localparam int T_PASS_DEF_S   = 15;
  localparam int T_ALARM_DEF_S  = 10;

  // Timer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } timer_state_t;

endpackage

// File: rtl/one_hz_divider.sv
// Prescaler producing a one-cycle enable once per second. Cleared by the
// timer restart so second boundaries line up with the countdown start.
module one_hz_divider #(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic one_hz_enable
);

  localparam int PW = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_FREQ_HZ - 1);

  logic [PW-1:0] presc;

  // A restart suppresses the tick so a reload never coincides with a decrement
  assign tick = (presc == LAST) && !clear;

  // Prescaler wraps at CLK_FREQ_HZ-1; the enable output is the registered tick
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      presc <= '0;
    end else if (presc == LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Registered enable, one cycle per wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      one_hz_enable <= 1'b0;
    end else begin
      one_hz_enable <= tick;
    end
  end

endmodule

// File: rtl/alarm_timer.sv
// Programmable countdown timer and 1 Hz time base for the anti-theft FSM.
// Holds four reprogrammable delay registers and counts the selected one
// down in whole seconds, pulsing expired when it reaches zero.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int T_ARM_DEF    = T_ARM_DEF_S,
  parameter int T_DRIVER_DEF = T_DRIVER_DEF_S,
  parameter int T_PASS_DEF   = T_PASS_DEF_S,
  parameter int T_ALARM_DEF  = T_ALARM_DEF_S
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       reprogram,
  input  logic [1:0] time_param_sel,
  input  logic [3:0] time_value,
  output logic       expired,
  output logic       one_hz_enable,
  output logic [3:0] remaining,
  output logic       counting
);

  logic [3:0]   params [0:3];
  timer_state_t state;
  logic         tick;

  one_hz_divider #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_div (
    .clock        (clock),
    .reset        (reset),
    .clear        (start_timer),
    .tick         (tick),
    .one_hz_enable(one_hz_enable)
  );

  // Delay registers; a zero value is rejected so a countdown is never empty
  always_ff @(posedge clock) begin
    if (reset) begin
      params[INT_ARM]    <= 4'(T_ARM_DEF);
      params[INT_DRIVER] <= 4'(T_DRIVER_DEF);
      params[INT_PASS]   <= 4'(T_PASS_DEF);
      params[INT_ALARM]  <= 4'(T_ALARM_DEF);
    end else if (reprogram && (time_value != 4'd0)) begin
      params[time_param_sel] <= time_value;
    end
  end

  // Countdown FSM. Any cycle with start_timer high (re)loads the count and
  // parks in LOAD, including the entry cycle from IDLE or RUN, so the value
  // sampled on the last start cycle is the one counted. A load reads the
  // register contents from before any same-cycle reprogram write.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= 4'd0;
      expired   <= 1'b0;
      counting  <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (start_timer) begin
        state     <= ST_LOAD;
        remaining <= params[interval];
        counting  <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            state    <= ST_RUN;
            counting <= 1'b1;
          end
          ST_RUN: begin
            if (tick) begin
              if (remaining == 4'd1) begin
                remaining <= 4'd0;
                expired   <= 1'b1;
                counting  <= 1'b0;
                state     <= ST_IDLE;
              end else begin
                remaining <= remaining - 4'd1;
              end
            end
          end
          default: begin
            state    <= ST_IDLE;
            counting <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer with CLK_FREQ_HZ = 4. A reference
// model tracks edges since the last clear and derives outputs arithmetically.
module tb_alarm_timer;

  localparam int F = 4;

  logic       clock;
  logic       reset;
  logic       start_timer;
  logic [1:0] interval;
  logic       reprogram;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
  logic       one_hz_enable;
  logic [3:0] remaining;
  logic       counting;

  int checks = 0;
  int fails  = 0;

  alarm_timer #(
    .CLK_FREQ_HZ (F),
    .T_ARM_DEF   (6),
    .T_DRIVER_DEF(8),
    .T_PASS_DEF  (15),
    .T_ALARM_DEF (10)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_timer   (start_timer),
    .interval      (interval),
    .reprogram     (reprogram),
    .time_param_sel(time_param_sel),
    .time_value    (time_value),
    .expired       (expired),
    .one_hz_enable (one_hz_enable),
    .remaining     (remaining),
    .counting      (counting)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: expiry at N*F edges after the last start edge, a 1 Hz
  // pulse every F edges after the last clear, remaining = N - elapsed/F.
  logic [3:0] m_par [4];
  int         m_cyc = 0;
  int         m_clr = 0;
  bit         m_act = 0;
  int         m_n   = 0;
  logic       m_exp = 0;
  logic       m_hz  = 0;
  logic [3:0] m_rem = 0;
  logic       m_cnt = 0;

  always @(posedge clock) begin : model
    int el;
    el = m_cyc - m_clr;
    m_cyc <= m_cyc + 1;
    if (reset) begin
      m_par[0] <= 4'd6;  m_par[1] <= 4'd8;
      m_par[2] <= 4'd15; m_par[3] <= 4'd10;
      m_clr <= m_cyc; m_act <= 0;
      m_exp <= 0; m_hz <= 0; m_rem <= 0; m_cnt <= 0;
    end else begin
      if (start_timer) begin
        m_rem <= m_par[interval];
        m_n   <= int'(m_par[interval]);
        m_clr <= m_cyc; m_act <= 1;
        m_exp <= 0; m_hz <= 0; m_cnt <= 0;
      end else begin
        m_hz  <= (el % F == 0);
        m_exp <= 0;
        if (m_act) begin
          if (el == m_n * F) begin
            m_exp <= 1; m_act <= 0; m_rem <= 0; m_cnt <= 0;
          end else begin
            m_rem <= 4'(m_n - el / F);
            m_cnt <= 1;
          end
        end else begin
          m_cnt <= 0;
        end
      end
      if (reprogram && time_value != 4'd0) m_par[time_param_sel] <= time_value;
    end
  end

  task automatic test_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({expired, one_hz_enable, remaining, counting} !== 7'd0) begin
      fails++;
      $display("FAIL reset_state: got exp/hz/rem/cnt=%b/%b/%0d/%b want 0/0/0/0",
               expired, one_hz_enable, remaining, counting);
    end
    reset = 1'b0;
  endtask

  task automatic test_free_running();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      checks++;
      if (one_hz_enable !== (k % F == 0) || expired !== 1'b0) begin
        fails++;
        $display("FAIL free_run k=%0d: got hz=%b exp=%b want hz=%b exp=0",
                 k, one_hz_enable, expired, (k % F == 0));
      end
    end
  endtask

  task automatic test_driver();
    int first_k = -1;
    int pulses  = 0;
    @(negedge clock); start_timer = 1'b1; interval = 2'b01;
    @(negedge clock); start_timer = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      checks++;
      if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
        fails++;
        $display("FAIL driver_model k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", k,
                 expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
      end
      if (k == 1) begin
        checks++;
        if (counting !== 1'b1 || remaining !== 4'd8) begin
          fails++;
          $display("FAIL driver_load: got cnt=%b rem=%0d want 1/8", counting, remaining);
        end
      end
      if (expired === 1'b1) begin pulses++; if (first_k < 0) first_k = k; end
    end
    checks++;
    if (first_k != 32 || pulses != 1) begin
      fails++;
      $display("FAIL driver_expire: got at %0d x%0d want at 32 x1", first_k, pulses);
    end
    checks++;
    if (remaining !== 4'd0 || counting !== 1'b0) begin
      fails++;
      $display("FAIL driver_after: got rem=%0d cnt=%b want 0/0", remaining, counting);
    end
  endtask

  task automatic test_reprogram();
    int first_k;
    for (int pass = 0; pass < 2; pass++) begin
      first_k = -1;
      @(negedge clock); reprogram = 1'b1; time_param_sel = 2'b11;
      time_value = (pass == 0) ? 4'd3 : 4'd0;
      @(negedge clock); reprogram = 1'b0; start_timer = 1'b1; interval = 2'b11;
      @(negedge clock); start_timer = 1'b0;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clock);
        checks++;
        if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
          fails++;
          $display("FAIL reprog_model p=%0d k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", pass, k,
                   expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
        end
        if (expired === 1'b1 && first_k < 0) first_k = k;
      end
      checks++;
      if (first_k != 12) begin
        fails++;
        $display("FAIL reprog_expire p=%0d: got %0d want 12", pass, first_k);
      end
    end
  endtask

  task automatic test_restart();
    int first_k = -1;
    int pulses  = 0;
    @(negedge clock); start_timer = 1'b1; interval = 2'b10;
    @(negedge clock); start_timer = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clock);
      checks++;
      if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
        fails++;
        $display("FAIL restart_model1 k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", k,
                 expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
      end
    end
    start_timer = 1'b1; interval = 2'b00;
    @(negedge clock); start_timer = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      checks++;
      if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
        fails++;
        $display("FAIL restart_model2 k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", k,
                 expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
      end
      if (k == 1) begin
        checks++;
        if (remaining !== 4'd6) begin
          fails++;
          $display("FAIL restart_reload: got rem=%0d want 6", remaining);
        end
      end
      if (expired === 1'b1) begin pulses++; if (first_k < 0) first_k = k; end
    end
    checks++;
    if (first_k != 24 || pulses != 1) begin
      fails++;
      $display("FAIL restart_expire: got at %0d x%0d want at 24 x1", first_k, pulses);
    end
  endtask

  task automatic test_reset_mid();
    int first_k = -1;
    int pulses  = 0;
    @(negedge clock); start_timer = 1'b1; interval = 2'b01;
    @(negedge clock); start_timer = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    checks++;
    if ({expired, one_hz_enable, remaining, counting} !== 7'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b/%b/%0d/%b want 0/0/0/0",
               expired, one_hz_enable, remaining, counting);
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (expired === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_mid_noexp: got %0d pulses want 0", pulses);
    end
    start_timer = 1'b1; interval = 2'b11;
    @(negedge clock); start_timer = 1'b0;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clock);
      checks++;
      if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
        fails++;
        $display("FAIL reset_mid_model k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", k,
                 expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
      end
      if (expired === 1'b1 && first_k < 0) first_k = k;
    end
    checks++;
    if (first_k != 40) begin
      fails++;
      $display("FAIL reset_mid_default: got %0d want 40", first_k);
    end
  endtask

  task automatic test_same_cycle();
    int first_k;
    for (int pass = 0; pass < 2; pass++) begin
      first_k = -1;
      @(negedge clock); start_timer = 1'b1; interval = 2'b01;
      if (pass == 0) begin reprogram = 1'b1; time_param_sel = 2'b01; time_value = 4'd2; end
      @(negedge clock); start_timer = 1'b0; reprogram = 1'b0;
      for (int k = 1; k <= 36; k++) begin
        @(negedge clock);
        checks++;
        if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
          fails++;
          $display("FAIL same_cycle_model p=%0d k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", pass, k,
                   expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
        end
        if (expired === 1'b1 && first_k < 0) first_k = k;
      end
      checks++;
      if (first_k != ((pass == 0) ? 32 : 8)) begin
        fails++;
        $display("FAIL same_cycle_expire p=%0d: got %0d want %0d", pass, first_k,
                 (pass == 0) ? 32 : 8);
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 1500; k++) begin
      @(negedge clock);
      checks++;
      if ({expired, one_hz_enable, remaining, counting} !== {m_exp, m_hz, m_rem, m_cnt}) begin
        fails++;
        $display("FAIL random_model k=%0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", k,
                 expired, one_hz_enable, remaining, counting, m_exp, m_hz, m_rem, m_cnt);
      end
      reset = ($urandom_range(0, 299) == 0);
      if (hold == 0 && $urandom_range(0, 29) == 0) hold = $urandom_range(1, 3);
      start_timer = (hold > 0);
      if (hold > 0) hold--;
      interval       = 2'($urandom_range(0, 3));
      reprogram      = ($urandom_range(0, 9) == 0);
      time_param_sel = 2'($urandom_range(0, 3));
      time_value     = 4'($urandom_range(0, 15));
    end
    @(negedge clock);
    reset = 1'b0; start_timer = 1'b0; reprogram = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_timer = 1'b0; interval = 2'b00;
    reprogram = 1'b0; time_param_sel = 2'b00; time_value = 4'd0;
    test_reset();
    test_free_running();
    test_driver();
    test_reprogram();
    test_restart();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
